// File: rtl/zoh_sequencer_pkg.sv
// zoh_sequencer_pkg: shared FSM encoding and default sizes for the interpolators
package zoh_sequencer_pkg;
  localparam int L_DEF = 4;
  localparam int DW_DEF = 16;
  localparam int OW_DEF = 20;
  typedef enum logic [1:0] {IDLE, HOLD, EMIT} state_t;
endpackage

// File: rtl/zoh_sample_buf.sv
// zoh_sample_buf: one-deep pending sample plus active sample, with sticky overrun
module zoh_sample_buf
  import zoh_sequencer_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          load,
  output logic          pend_full,
  output logic [DW-1:0] active,
  output logic          overrun
);
  logic [DW-1:0] pend;
  // a load frees the slot in the same cycle, so a coincident sample is accepted
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      pend      <= '0;
      pend_full <= 1'b0;
      active    <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load) active <= pend;
      if (in_valid && (!pend_full || load)) pend <= in_data;
      pend_full <= in_valid || (pend_full && !load);
      if (in_valid && pend_full && !load) overrun <= 1'b1;
    end
endmodule

// File: rtl/zoh_sequencer.sv
// zoh_sequencer: zero-order-hold upsampler emitting each input sample L times on rate_tick
module zoh_sequencer
  import zoh_sequencer_pkg::*;
#(
  parameter  int L  = L_DEF,
  parameter  int DW = DW_DEF,
  parameter  int OW = OW_DEF,
  localparam int PW = $clog2(L)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          rate_tick,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  output logic [PW-1:0] phase,
  output logic          overrun,
  output logic          underrun,
  output logic          tick_miss
);
  state_t        state, nxt;
  logic          pend_full, slot0, load;
  logic [DW-1:0] active;
  assign slot0 = state == HOLD && rate_tick && phase == '0;
  assign load  = slot0 && pend_full;
  zoh_sample_buf #(.DW(DW)) u_buf (
    .CLK(CLK),
    .RST(RST),
    .in_valid(in_valid),
    .in_data(in_data),
    .load(load),
    .pend_full(pend_full),
    .active(active),
    .overrun(overrun)
  );
  always_comb
    nxt = state == IDLE ? (pend_full ? HOLD : IDLE) :
          state == HOLD ? (rate_tick ? EMIT : HOLD) :
          (out_ready ? HOLD : EMIT);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      phase     <= '0;
      underrun  <= 1'b0;
      tick_miss <= 1'b0;
    end else begin
      underrun <= slot0 && !pend_full;
      if (state == EMIT && out_ready) phase <= phase == PW'(L - 1) ? '0 : phase + 1'b1;
      if (state == EMIT && rate_tick) tick_miss <= 1'b1;
    end
  assign out_valid = state == EMIT;
  assign out_data  = {active, {(OW - DW){1'b0}}};
endmodule
